// File: rtl/risc8_intc.sv
// risc8_intc: interrupt controller for the 8-bit RISC core, on the COM bus.
// It latches rising edges on the irq lines as pending bits and masks them.
// The lowest-numbered enabled pending line is dispatched as a one-cycle
// cpu_int pulse, with its vector on com_rd. No further dispatch happens until
// the core writes EOI.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   irq[N_IRQ]      request lines, rising-edge sensitive
//   com_addr/com_wr COM address and write data from the core
//   com_we          COM write strobe
//   com_rd          read data: vector during the cpu_int cycle, else register data
//   com_hit         read-mux select: address in window or cpu_int high
//   cpu_int         interrupt pulse to the core (registered)
// com_rd and com_hit decode com_addr combinationally so that reads complete
// in the same cycle as the address.
module risc8_intc #(
  parameter int unsigned N_IRQ     = 8,
  parameter logic [7:0]  BASE_ADDR = 8'hF0,
  parameter logic [7:0]  VEC_BASE  = 8'h10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic [7:0]       com_addr,
  input  logic [7:0]       com_wr,
  input  logic             com_we,
  output logic [7:0]       com_rd,
  output logic             com_hit,
  output logic             cpu_int
);

  typedef enum logic [1:0] {IDLE, SIGNAL, SERVICE} state_t;

  state_t           state, state_d;
  logic [N_IRQ-1:0] irq_q, mask, mask_d, pend, pend_d, pend_clr;
  logic [N_IRQ-1:0] rise, req;
  logic [2:0]       cur_id, cur_id_d, pick;
  logic             cpu_int_d;
  logic [7:0]       offset, reg_rd;
  logic             in_win, wr_mask, wr_pend, wr_eoi;

  // Address decode; subtraction keeps the window check correct near 8'hFF.
  assign offset  = com_addr - BASE_ADDR;
  assign in_win  = offset < 8'd4;
  assign wr_mask = com_we && in_win && (offset[1:0] == 2'd0);
  assign wr_pend = com_we && in_win && (offset[1:0] == 2'd1);
  assign wr_eoi  = com_we && in_win && (offset[1:0] == 2'd2);

  assign rise = irq & ~irq_q;
  assign req  = pend & mask;

  // Lowest-numbered enabled pending line; scanning downward leaves the lowest.
  always_comb begin
    pick = 3'd0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) pick = 3'(i);
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d   = state;
    cur_id_d  = cur_id;
    mask_d    = mask;
    pend_clr  = '0;
    pend_d    = pend;
    cpu_int_d = 1'b0;
    if (wr_mask) mask_d = com_wr[N_IRQ-1:0];
    if (wr_pend) pend_clr = com_wr[N_IRQ-1:0];
    case (state)
      IDLE: begin
        if (|req) begin
          state_d  = SIGNAL;
          cur_id_d = pick;
          for (int i = 0; i < int'(N_IRQ); i++) begin
            if (3'(i) == pick) pend_clr[i] = 1'b1;
          end
        end
      end
      SIGNAL:  state_d = SERVICE;  // EOI during the pulse cycle is ignored
      SERVICE: begin
        if (wr_eoi) begin
          state_d  = IDLE;
          cur_id_d = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new edge wins over any clear in the same cycle.
    pend_d    = (pend & ~pend_clr) | rise;
    cpu_int_d = (state_d == SIGNAL);
  end

  // State and register flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      irq_q   <= '0;
      mask    <= '0;
      pend    <= '0;
      cur_id  <= 3'd0;
      cpu_int <= 1'b0;
    end else begin
      state   <= state_d;
      irq_q   <= irq;
      mask    <= mask_d;
      pend    <= pend_d;
      cur_id  <= cur_id_d;
      cpu_int <= cpu_int_d;
    end
  end

  // Register read mux.
  always_comb begin
    reg_rd = 8'h00;
    case (offset[1:0])
      2'd0:    reg_rd = 8'(mask);
      2'd1:    reg_rd = 8'(pend);
      2'd2:    reg_rd = 8'h00;
      default: reg_rd = {state != IDLE, 4'b0000, cur_id};
    endcase
  end

  // The vector overrides register data for the pulse cycle.
  assign com_hit = in_win | cpu_int;
  assign com_rd  = cpu_int ? (VEC_BASE + {5'b00000, cur_id})
                           : (in_win ? reg_rd : 8'h00);

endmodule

// File: tb/tb_risc8_intc.sv
// Directed testbench for risc8_intc (default parameters: base F0, vectors 10+).
module tb_risc8_intc;

  logic       clk;
  logic       rst;
  logic [7:0] irq;
  logic [7:0] com_addr;
  logic [7:0] com_wr;
  logic       com_we;
  logic [7:0] com_rd;
  logic       com_hit;
  logic       cpu_int;

  int total;
  int bad;

  risc8_intc dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .com_addr (com_addr),
    .com_wr   (com_wr),
    .com_we   (com_we),
    .com_rd   (com_rd),
    .com_hit  (com_hit),
    .cpu_int  (cpu_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    com_addr = a;
    com_wr   = d;
    com_we   = 1'b1;
    step();
    com_we   = 1'b0;
    com_addr = 8'h00;
  endtask

  // Set the read address and let the combinational read path settle.
  task automatic rd(input logic [7:0] a);
    com_addr = a;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; irq = 8'h00; com_we = 1'b0; com_addr = 8'h00; com_wr = 8'h00;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rd(8'h00);
    total++; if (cpu_int !== 1'b0) begin bad++; $display("FAIL rst_int got=%0b exp=0", cpu_int); end
    total++; if (com_hit !== 1'b0) begin bad++; $display("FAIL rst_hit got=%0b exp=0", com_hit); end
    total++; if (com_rd !== 8'h00) begin bad++; $display("FAIL rst_rd got=%h exp=00", com_rd); end
    rd(8'hF0);
    total++; if (com_rd !== 8'h00 || com_hit !== 1'b1) begin bad++; $display("FAIL rst_mask got=%h/%0b exp=00/1", com_rd, com_hit); end
    rd(8'hF3);
    total++; if (com_rd !== 8'h00) begin bad++; $display("FAIL rst_status got=%h exp=00", com_rd); end
    rd(8'hF4);
    total++; if (com_hit !== 1'b0) begin bad++; $display("FAIL rst_outwin_hit got=%0b exp=0", com_hit); end
  endtask

  task automatic test_single();
    do_reset();
    wr(8'hF0, 8'h04);
    irq = 8'h04;
    step();                       // sample edge k
    irq = 8'h00;
    total++; if (cpu_int !== 1'b0) begin bad++; $display("FAIL t1_early got=%0b exp=0", cpu_int); end
    step();                       // edge k+1: dispatch
    total++; if (cpu_int !== 1'b1) begin bad++; $display("FAIL t1_int got=%0b exp=1", cpu_int); end
    total++; if (com_rd !== 8'h12 || com_hit !== 1'b1) begin bad++; $display("FAIL t1_vec got=%h/%0b exp=12/1", com_rd, com_hit); end
    step();
    total++; if (cpu_int !== 1'b0) begin bad++; $display("FAIL t1_pulse_len got=%0b exp=0", cpu_int); end
    rd(8'hF3);
    total++; if (com_rd !== 8'h82) begin bad++; $display("FAIL t1_status got=%h exp=82", com_rd); end
    rd(8'hF1);
    total++; if (com_rd !== 8'h00) begin bad++; $display("FAIL t1_pend got=%h exp=00", com_rd); end
    rd(8'hF2);
    total++; if (com_rd !== 8'h00) begin bad++; $display("FAIL t1_eoi_read got=%h exp=00", com_rd); end
  endtask

  task automatic test_priority();
    do_reset();
    wr(8'hF0, 8'hFF);
    irq = 8'h22;
    step();
    irq = 8'h00;
    step();
    total++; if (cpu_int !== 1'b1 || com_rd !== 8'h11) begin bad++; $display("FAIL t2_first got=%0b/%h exp=1/11", cpu_int, com_rd); end
    step();
    wr(8'hF2, 8'h00);             // EOI -> IDLE
    rd(8'hF3);
    total++; if (cpu_int !== 1'b0 || com_rd !== 8'h00) begin bad++; $display("FAIL t2_idle got=%0b/%h exp=0/00", cpu_int, com_rd); end
    step();
    total++; if (cpu_int !== 1'b1 || com_rd !== 8'h15) begin bad++; $display("FAIL t2_second got=%0b/%h exp=1/15", cpu_int, com_rd); end
    step();
    wr(8'hF2, 8'h00);
    rd(8'hF3);
    total++; if (com_rd !== 8'h00) begin bad++; $display("FAIL t2_status got=%h exp=00", com_rd); end
  endtask

  task automatic test_mask();
    do_reset();
    irq = 8'h08;
    step();
    irq = 8'h00;
    step();
    step();
    total++; if (cpu_int !== 1'b0) begin bad++; $display("FAIL t3_masked_int got=%0b exp=0", cpu_int); end
    rd(8'hF1);
    total++; if (com_rd !== 8'h08) begin bad++; $display("FAIL t3_pend got=%h exp=08", com_rd); end
    wr(8'hF0, 8'h08);
    step();
    total++; if (cpu_int !== 1'b1 || com_rd !== 8'h13) begin bad++; $display("FAIL t3_unmask got=%0b/%h exp=1/13", cpu_int, com_rd); end
    step();
    wr(8'hF2, 8'h00);
    // Clear pending before unmasking: nothing dispatches.
    do_reset();
    irq = 8'h08;
    step();
    irq = 8'h00;
    wr(8'hF1, 8'h08);
    wr(8'hF0, 8'h08);
    step();
    total++; if (cpu_int !== 1'b0) begin bad++; $display("FAIL t3_w1c_int got=%0b exp=0", cpu_int); end
    step();
    rd(8'hF1);
    total++; if (com_rd !== 8'h00 || cpu_int !== 1'b0) begin bad++; $display("FAIL t3_w1c_pend got=%h/%0b exp=00/0", com_rd, cpu_int); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr(8'hF0, 8'h01);
    irq = 8'h01;
    step();
    step();
    total++; if (cpu_int !== 1'b1 || com_rd !== 8'h10) begin bad++; $display("FAIL t4_first got=%0b/%h exp=1/10", cpu_int, com_rd); end
    step();
    irq = 8'h00;
    step();
    irq = 8'h01;                  // re-request while in service
    step();
    step();
    total++; if (cpu_int !== 1'b0) begin bad++; $display("FAIL t4_nested got=%0b exp=0", cpu_int); end
    rd(8'hF1);
    total++; if (com_rd !== 8'h01) begin bad++; $display("FAIL t4_pend got=%h exp=01", com_rd); end
    rd(8'hF3);
    total++; if (com_rd !== 8'h80) begin bad++; $display("FAIL t4_status got=%h exp=80", com_rd); end
    wr(8'hF2, 8'h00);
    total++; if (cpu_int !== 1'b0) begin bad++; $display("FAIL t4_idle got=%0b exp=0", cpu_int); end
    step();
    total++; if (cpu_int !== 1'b1 || com_rd !== 8'h10) begin bad++; $display("FAIL t4_second got=%0b/%h exp=1/10", cpu_int, com_rd); end
    step();
    wr(8'hF2, 8'h00);
    step();
    step();
    rd(8'hF1);
    total++; if (cpu_int !== 1'b0 || com_rd !== 8'h00) begin bad++; $display("FAIL t4_held got=%0b/%h exp=0/00", cpu_int, com_rd); end
    irq = 8'h00;
  endtask

  task automatic test_set_wins();
    do_reset();
    irq      = 8'h10;
    com_addr = 8'hF1;
    com_wr   = 8'h10;
    com_we   = 1'b1;
    step();
    com_we = 1'b0;
    irq    = 8'h00;
    rd(8'hF1);
    total++; if (com_rd !== 8'h10) begin bad++; $display("FAIL t5_set_wins got=%h exp=10", com_rd); end
    total++; if (cpu_int !== 1'b0) begin bad++; $display("FAIL t5_int got=%0b exp=0", cpu_int); end
  endtask

  task automatic test_reset_in_service();
    do_reset();
    wr(8'hF0, 8'hFF);
    irq = 8'h04;
    step();
    irq = 8'h00;
    step();
    step();
    irq = 8'h03;
    step();
    irq = 8'h00;
    rd(8'hF1);
    total++; if (com_rd !== 8'h03) begin bad++; $display("FAIL t6_pend_pre got=%h exp=03", com_rd); end
    rd(8'hF3);
    total++; if (com_rd !== 8'h82) begin bad++; $display("FAIL t6_status_pre got=%h exp=82", com_rd); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd(8'hF3);
    total++; if (com_rd !== 8'h00 || cpu_int !== 1'b0) begin bad++; $display("FAIL t6_status got=%h/%0b exp=00/0", com_rd, cpu_int); end
    rd(8'hF1);
    total++; if (com_rd !== 8'h00) begin bad++; $display("FAIL t6_pend got=%h exp=00", com_rd); end
    rd(8'hF0);
    total++; if (com_rd !== 8'h00) begin bad++; $display("FAIL t6_mask got=%h exp=00", com_rd); end
    wr(8'hF2, 8'h00);
    rd(8'hF3);
    total++; if (com_rd !== 8'h00 || cpu_int !== 1'b0) begin bad++; $display("FAIL t6_eoi_idle got=%h/%0b exp=00/0", com_rd, cpu_int); end
    step();
    total++; if (cpu_int !== 1'b0) begin bad++; $display("FAIL t6_quiet got=%0b exp=0", cpu_int); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_back_to_back();
    test_set_wins();
    test_reset_in_service();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
